dmem_arbiter: RTL

Arbiter that shares the single-port data memory between the core's MEM stage and a debug/loader port. Core has priority; the debug port gets idle cycles, and a starvation limit forces a one-cycle core stall. A halt mode freezes the core and gives the debug port exclusive access. The block sits between the core datapath (ALU result, rs2 data, MemWE) and `DataMem`. Its `cpu_stall` output drives PC hold and gates RegWE in the core.

---
 rtl/dmem_arbiter.sv | 60 ++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares DataMem between the core MEM stage (priority) and a debug port with starvation limit and halt mode
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  input  logic              dbg_halt,
  output logic              halted,
  output logic [15:0]       stall_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic cpu_go;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      dbg_rdata <= '0;
      dbg_rvalid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= (dbg_req && !dbg_gnt) ? wait_cnt + CW'(1) : '0;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
      stall_cnt <= stall_cnt + 16'(cpu_stall && stall_cnt != 16'hFFFF);
    end
  always_comb begin
    state_nx = dbg_halt ? HALTED : RUN;
    halted = state == HALTED;
    dbg_gnt = !rst && dbg_req && (halted || !cpu_req || wait_cnt == CW'(WAIT_LIMIT));
    cpu_stall = !rst && (halted || (cpu_req && dbg_gnt));
    cpu_go = !rst && cpu_req && !cpu_stall;
    mem_we = dbg_gnt ? dbg_we : cpu_go && cpu_we;
    mem_addr = dbg_gnt ? dbg_addr : cpu_addr;
    mem_wdata = dbg_gnt ? dbg_wdata : cpu_go ? cpu_wdata : '0;
    cpu_rdata = mem_rdata;
  end
endmodule
